// File: rtl/hazard_unit.sv
// Hazard unit: shadow EX/MEM/WB pipe driving forwarding, load-use stall and flush.
// Define HAZARD_FWD_EN for forwarding; otherwise hazards resolve by stalling.
module hazard_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] id_instruction,
  input  logic        id_reg_write,
  input  logic [1:0]  id_reg_write_mux,
  input  logic        id_reg_B_mux,
  input  logic        id_alu_B_mux,
  input  logic        id_use_A,
  input  logic        id_use_B,
  input  logic        id_taken,
  output logic [1:0]  forward_A,
  output logic [1:0]  forward_B,
  output logic        stall,
  output logic        flush
);

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       is_load;
    logic [2:0] dest;
  } stg_t;

  typedef struct packed {
    stg_t       s;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic       use_a;
    logic       use_b;
    logic       alu_b_mux;
  } ex_t;

  ex_t  ex_q, ex_d;
  stg_t mem_q, mem_d;
  stg_t wb_q, wb_d;

  logic [2:0] id_dest;
  logic [2:0] id_src_a;
  logic [2:0] id_src_b;
  logic       stall_raw;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  function automatic logic writes(input stg_t s, input logic [2:0] r);
    return s.valid & s.reg_write & (s.dest == r);
  endfunction

  function automatic logic hit(input stg_t s, input logic ua,
                               input logic [2:0] ra, input logic ub,
                               input logic [2:0] rb);
    return (ua & writes(s, ra)) | (ub & writes(s, rb));
  endfunction

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic use_r,
                                         input logic [2:0] r,
                                         input stg_t m,
                                         input stg_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_r) begin
      if (writes(m, r))
        sel = 2'b10;
      else if (writes(w, r))
        sel = 2'b11;
    end
    return sel;
  endfunction
`endif

  assign id_dest  = id_instruction[13:11];
  assign id_src_a = id_instruction[10:8];
  assign id_src_b = id_reg_B_mux ? id_instruction[13:11]
                                 : id_instruction[7:5];

  always_comb begin
`ifdef HAZARD_FWD_EN
    // Only a load in EX is too late to forward from.
    stall_raw = ex_q.s.is_load &
                hit(ex_q.s, id_use_A, id_src_a, id_use_B, id_src_b);
    fwd_a = fwd_sel(ex_q.use_a, ex_q.src_a, mem_q, wb_q);
    fwd_b = ex_q.alu_b_mux ? 2'b01
          : fwd_sel(ex_q.use_b, ex_q.src_b, mem_q, wb_q);
`else
    stall_raw = hit(ex_q.s, id_use_A, id_src_a, id_use_B, id_src_b) |
                hit(mem_q, id_use_A, id_src_a, id_use_B, id_src_b) |
                hit(wb_q, id_use_A, id_src_a, id_use_B, id_src_b);
    fwd_a = 2'b00;
    fwd_b = ex_q.alu_b_mux ? 2'b01 : 2'b00;
`endif
  end

  assign stall     = stall_raw & ~reset;
  assign flush     = id_taken & ~stall & ~reset;
  assign forward_A = reset ? 2'b00 : fwd_a;
  assign forward_B = reset ? 2'b00 : fwd_b;

  always_comb begin
    ex_d = '0;
    if (!stall) begin
      ex_d.s.valid     = 1'b1;
      ex_d.s.reg_write = id_reg_write;
      ex_d.s.is_load   = (id_reg_write_mux == 2'b10);
      ex_d.s.dest      = id_dest;
      ex_d.src_a       = id_src_a;
      ex_d.src_b       = id_src_b;
      ex_d.use_a       = id_use_A;
      ex_d.use_b       = id_use_B;
      ex_d.alu_b_mux   = id_alu_B_mux;
    end
    mem_d = ex_q.s;
    wb_d  = mem_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{id_instruction[18:14], id_instruction[4:0],
                       wb_q.is_load, ex_q.src_a, ex_q.src_b,
                       ex_q.use_a, ex_q.use_b};

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: issue-history model plus directed and random stimulus.
// Honours HAZARD_FWD_EN the same way the design does.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] id_instruction;
  logic        id_reg_write;
  logic [1:0]  id_reg_write_mux;
  logic        id_reg_B_mux;
  logic        id_alu_B_mux;
  logic        id_use_A;
  logic        id_use_B;
  logic        id_taken;
  logic [1:0]  forward_A;
  logic [1:0]  forward_B;
  logic        stall;
  logic        flush;

  hazard_unit dut (
    .clk              (clk),
    .reset            (reset),
    .id_instruction   (id_instruction),
    .id_reg_write     (id_reg_write),
    .id_reg_write_mux (id_reg_write_mux),
    .id_reg_B_mux     (id_reg_B_mux),
    .id_alu_B_mux     (id_alu_B_mux),
    .id_use_A         (id_use_A),
    .id_use_B         (id_use_B),
    .id_taken         (id_taken),
    .forward_A        (forward_A),
    .forward_B        (forward_B),
    .stall            (stall),
    .flush            (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit       rw;
    bit       ld;
    bit [2:0] d;
    bit [2:0] sa;
    bit [2:0] sb;
    bit       ua;
    bit       ub;
    bit       bm;
  } ent_t;

  // issued[0] is in EX, issued[1] in MEM, issued[2] in WB
  ent_t     issued[$];
  ent_t     bub;
  int       checks   = 0;
  int       failures = 0;
  bit       exp_stall;
  bit       exp_flush;
  bit [1:0] exp_fa;
  bit [1:0] exp_fb;

  function automatic ent_t cur_id();
    ent_t e;
    e.v  = 1'b1;
    e.rw = id_reg_write;
    e.ld = (id_reg_write_mux == 2'b10);
    e.d  = id_instruction[13:11];
    e.sa = id_instruction[10:8];
    e.sb = id_reg_B_mux ? id_instruction[13:11] : id_instruction[7:5];
    e.ua = id_use_A;
    e.ub = id_use_B;
    e.bm = id_alu_B_mux;
    return e;
  endfunction

  function automatic bit wr(ent_t e, bit [2:0] r);
    return e.v && e.rw && (e.d == r);
  endfunction

  function automatic bit uses(ent_t p, ent_t c);
    return (c.ua && wr(p, c.sa)) || (c.ub && wr(p, c.sb));
  endfunction

  // youngest older instruction (1 = MEM, 2 = WB) producing r
  function automatic bit [1:0] fsel(bit u, bit [2:0] r);
    if (!u) return 2'b00;
    for (int k = 1; k <= 2; k++)
      if (wr(issued[k], r)) return (k == 1) ? 2'b10 : 2'b11;
    return 2'b00;
  endfunction

  task automatic compute_expected();
    ent_t id;
    ent_t ex;
    id = cur_id();
    ex = issued[0];
`ifdef HAZARD_FWD_EN
    exp_stall = ex.ld && uses(ex, id);
    exp_fa    = fsel(ex.ua, ex.sa);
    exp_fb    = ex.bm ? 2'b01 : fsel(ex.ub, ex.sb);
`else
    exp_stall = uses(issued[0], id) || uses(issued[1], id) ||
                uses(issued[2], id);
    exp_fa    = 2'b00;
    exp_fb    = ex.bm ? 2'b01 : 2'b00;
`endif
    exp_flush = id_taken && !exp_stall;
    if (reset) begin
      exp_stall = 1'b0;
      exp_flush = 1'b0;
      exp_fa    = 2'b00;
      exp_fb    = 2'b00;
    end
  endtask

  task automatic chk(string n, logic [1:0] got, logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", n, got, exp, $time);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compute_expected();
    chk("stall", {1'b0, stall}, {1'b0, exp_stall});
    chk("flush", {1'b0, flush}, {1'b0, exp_flush});
    chk("forward_A", forward_A, exp_fa);
    chk("forward_B", forward_B, exp_fb);
  endtask

  task automatic adv();
    @(posedge clk);
    if (reset) begin
      issued.delete();
      repeat (3) issued.push_back(bub);
    end else begin
      issued.push_front(exp_stall ? bub : cur_id());
      void'(issued.pop_back());
    end
    #1;
  endtask

  task automatic set_id(input bit rw, input bit [1:0] mx,
                        input bit [2:0] d, input bit [2:0] sa,
                        input bit [2:0] sb, input bit rbm,
                        input bit abm, input bit ua, input bit ub,
                        input bit tk);
    id_instruction   = {5'b0, d, sa, sb, 5'b0};
    id_reg_write     = rw;
    id_reg_write_mux = mx;
    id_reg_B_mux     = rbm;
    id_alu_B_mux     = abm;
    id_use_A         = ua;
    id_use_B         = ub;
    id_taken         = tk;
  endtask

  task automatic nop(input bit tk);
    set_id(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, tk);
  endtask

  task automatic add(input bit [2:0] d, input bit [2:0] sa,
                     input bit [2:0] sb, input bit tk);
    set_id(1, 2'b00, d, sa, sb, 0, 0, 1, 1, tk);
  endtask

  task automatic load(input bit [2:0] d, input bit [2:0] sa);
    set_id(1, 2'b10, d, sa, 0, 0, 1, 1, 0, 0);
  endtask

  int n_stall;

  initial begin
    bub = '{default: 0};
    repeat (3) issued.push_back(bub);
`ifdef HAZARD_FWD_EN
    n_stall = 1;
`else
    n_stall = 3;
`endif
    reset = 1'b1;
    nop(0);
    settle();
    chk("rst_fwdA", forward_A, 2'b00);
    chk("rst_stall", {1'b0, stall}, 2'b00);
    adv();
    adv();
    reset = 1'b0;

    // unconditional redirect without hazard
    nop(1);
    settle();
    chk("taken_flush", {1'b0, flush}, 2'b01);
    adv();
    nop(0);
    settle();
    adv();

    // redirect during a load-use stall is deferred
    load(4, 0);
    settle();
    adv();
    add(5, 4, 0, 1);
    settle();
    chk("lu_taken_stall", {1'b0, stall}, 2'b01);
    chk("lu_taken_flush", {1'b0, flush}, 2'b00);
    adv();
    for (int i = 1; i < n_stall; i++) begin
      settle();
      chk("lu_taken_hold", {1'b0, flush}, 2'b00);
      adv();
    end
    settle();
    chk("lu_taken_late_flush", {1'b0, flush}, 2'b01);
    adv();
    nop(0);
    repeat (3) begin
      settle();
      adv();
    end

`ifdef HAZARD_FWD_EN
    add(1, 2, 3, 0);
    settle();
    adv();
    add(2, 1, 3, 0);
    settle();
    chk("b2b_nostall", {1'b0, stall}, 2'b00);
    adv();
    nop(0);
    settle();
    chk("b2b_fwdA", forward_A, 2'b10);
    adv();

    add(1, 5, 6, 0);
    settle();
    adv();
    nop(0);
    settle();
    adv();
    set_id(1, 2'b00, 3, 5, 1, 0, 0, 0, 1, 0);
    settle();
    adv();
    nop(0);
    settle();
    chk("wb_fwdB", forward_B, 2'b11);
    adv();

    add(1, 5, 6, 0);
    settle();
    adv();
    add(1, 6, 7, 0);
    settle();
    adv();
    set_id(1, 2'b00, 3, 5, 1, 0, 0, 0, 1, 0);
    settle();
    adv();
    nop(0);
    settle();
    chk("mem_prio_fwdB", forward_B, 2'b10);
    adv();

    load(4, 0);
    settle();
    adv();
    add(5, 4, 0, 0);
    settle();
    chk("lu_stall", {1'b0, stall}, 2'b01);
    adv();
    settle();
    chk("lu_one_cycle", {1'b0, stall}, 2'b00);
    chk("lu_bubble_A", forward_A, 2'b00);
    chk("lu_bubble_B", forward_B, 2'b00);
    adv();
    nop(0);
    settle();
    chk("lu_fwdA", forward_A, 2'b11);
    adv();
`else
    nop(0);
    settle();
    adv();
    add(1, 2, 3, 0);
    settle();
    adv();
    add(2, 1, 3, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("nofwd_stall", {1'b0, stall}, 2'b01);
      chk("nofwd_fwdA", forward_A, 2'b00);
      adv();
    end
    settle();
    chk("nofwd_release", {1'b0, stall}, 2'b00);
    adv();
`endif

    // reset in the middle of a stall
    nop(0);
    repeat (3) begin
      settle();
      adv();
    end
    load(1, 0);
    settle();
    adv();
    add(2, 1, 3, 0);
    settle();
    chk("pre_rst_stall", {1'b0, stall}, 2'b01);
    reset = 1'b1;
    #1;
    chk("rst_drop_stall", {1'b0, stall}, 2'b00);
    chk("rst_drop_fwdA", forward_A, 2'b00);
    chk("rst_drop_fwdB", forward_B, 2'b00);
    adv();
    adv();
    reset = 1'b0;
    add(3, 4, 5, 0);
    settle();
    chk("post_rst_nostall", {1'b0, stall}, 2'b00);
    adv();

    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 100) begin
        reset = 1'b1;
        settle();
        adv();
        reset = 1'b0;
      end else begin
        if (!exp_stall) begin
          if (exp_flush) begin
            nop(0);
          end else begin
            set_id(($urandom % 4) != 0, 2'($urandom),
                   3'($urandom % 4), 3'($urandom % 4),
                   3'($urandom % 4), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), ($urandom % 8) == 0);
            id_instruction[18:14] = 5'($urandom);
            id_instruction[4:0]   = 5'($urandom);
          end
        end
        settle();
        adv();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 id_instruction  input  19  instruction currently in ID (IF/ID register output); dest=[13:11], srcA=[10:8], srcB=[7:5] or [13:11].
REQ-004 id_reg_write  input  1  decoded: ID instruction writes register file.
REQ-005 id_reg_write_mux  input  2  decoded writeback select; 2'b10 = load (memory data).
REQ-006 id_reg_B_mux  input  1  0: srcB=[7:5]; 1: srcB=[13:11].
REQ-007 id_alu_B_mux  input  1  1: ALU B operand is immediate [7:0].
REQ-008 id_use_A / id_use_B  input  1 each  ID instruction reads srcA / srcB.
REQ-009 id_taken  input  1  ID instruction redirects PC (branch taken, jump, call, return).
REQ-010 forward_A  output  2  EX operand A select: 00 regfile, 10 EX/MEM ALU result, 11 MEM/WB writeback data.
REQ-011 forward_B  output  2  as forward_A, plus 01 immediate.
REQ-012 stall  output  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-013 flush  output  1  clear IF/ID at next edge.

Function
REQ-014 Unit SHALL keep a shadow pipe of three stages EX, MEM, WB; each holds valid, reg_write, is_load (reg_write_mux==10), dest[2:0]; EX also holds srcA, srcB, use_A, use_B, alu_B_mux.
REQ-015 Every clock edge the shadow pipe SHALL advance ID->EX->MEM->WB; WB contents are discarded.
REQ-016 When stall=1 at an edge, EX SHALL load a bubble (valid=0, reg_write=0); MEM and WB still advance.
REQ-017 A stage "writes r" iff valid & reg_write & dest==r.
REQ-018 forward_A (combinational, from EX stage): 00 if !EX.use_A; else 10 if MEM writes EX.srcA; else 11 if WB writes EX.srcA; else 00. MEM priority over WB.
REQ-019 forward_B: 01 if EX.alu_B_mux; else same rule as REQ-018 using srcB/use_B.
REQ-020 Load-use: stall=1 when EX.is_load and EX writes an ID source that is used (srcA with id_use_A, srcB with id_use_B); exactly one stall cycle, after which the consumer forwards 11.
REQ-021 MEM stage holding a load SHALL never be selected by 10 (guaranteed by REQ-020).
REQ-022 flush = id_taken & !stall; when stall and id_taken coincide, stall wins and the redirect is re-evaluated next cycle.
REQ-023 No special treatment of register 0; any dest may be forwarded.
REQ-024 A flushed/bubbled ID instruction (id_reg_write=0, use flags 0) SHALL never cause stall or forwarding.

Reset
REQ-025 reset=1 SHALL asynchronously clear all shadow-stage valid bits and stored fields to 0.
REQ-026 During and after reset until the first real instruction: forward_A=00, forward_B=00 (unless EX.alu_B_mux), stall=0, flush=0 (outputs gated by !reset).
REQ-027 Reset asserted mid-stall SHALL drop stall in the same cycle; no residual bubble after release.

Configuration
REQ-028 Macro HAZARD_FWD_EN defined: forwarding per REQ-018..021.
REQ-029 HAZARD_FWD_EN undefined: forward_A=00 always, forward_B=01 if EX.alu_B_mux else 00; stall=1 while any of EX, MEM, WB writes a used ID source (up to 3 stall cycles per hazard); REQ-020 subsumed.

Verification
REQ-030 ADD r1 then ADD r2,r1,r3 back-to-back (FWD_EN) -> consumer in EX: forward_A=10, stall never 1.
REQ-031 ADD r1, unrelated NOP, ADD using r1 as srcB -> forward_B=11; with intervening ADD r1 too -> forward_B=10 (MEM priority).
REQ-032 LOAD r4 then ADD using r4 -> stall=1 exactly 1 cycle, bubble in EX, then forward_A=11.
REQ-033 id_taken=1 with no hazard -> flush=1 same cycle; id_taken=1 during load-use stall -> flush=0 that cycle, flush=1 next cycle.
REQ-034 FWD_EN undefined: ADD r1 then ADD reading r1 -> stall=1 for 3 consecutive cycles, forward_A=00 throughout.
REQ-035 reset pulse while stall=1 -> stall=0, forward_A=forward_B=00 immediately; after release, independent instruction issues with no stall.
